pipeline_ctrl: RTL
==================

Name: pipeline_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage pipeline. Generates write-enable and flush controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. Handles load-use stalls, taken-branch flushes, and multi-cycle instruction- and data-cache fills through a fill request/done handshake. Sits beside the datapath, consuming hazard inputs from ID/EX and EX/MEM and the cache miss lines.

Parameters:
REG_W, 5, register specifier width
ADDR_W, 32, PC / branch target width
CNT_W, 32, stall performance counter width

Ports:
clock  in  1  pipeline clock, rising edge
reset_n  in  1  asynchronous active-low reset
if_id_rs  in  REG_W  rs of instruction in IF/ID
if_id_rt  in  REG_W  rt of instruction in IF/ID
if_id_uses_rt  in  1  IF/ID instruction reads rt as a source
id_ex_mem_read  in  1  ID/EX instruction is a load
id_ex_rt  in  REG_W  load destination in ID/EX
branch_taken  in  1  EX/MEM pcSrc, branch resolved taken
branch_target  in  ADDR_W  EX/MEM branch target
icache_miss  in  1  fetch miss this cycle
dcache_miss  in  1  MEM-stage access missed this cycle
fill_done  in  1  one-cycle pulse, outstanding fill complete
pc_write  out  1  PC register enable
if_id_write  out  1  IF/ID enable
id_ex_write  out  1  ID/EX enable
ex_mem_write  out  1  EX/MEM enable
if_id_flush  out  1  bubble into IF/ID
id_ex_flush  out  1  bubble into ID/EX
ex_mem_flush  out  1  bubble into EX/MEM (drives its flush input)
mem_wb_flush  out  1  bubble into MEM/WB
redirect_valid  out  1  PC mux selects redirect_pc this cycle
redirect_pc  out  ADDR_W  redirect address
fill_req  out  1  registered one-cycle pulse starting a fill
fill_is_data  out  1  qualifies fill_req: 1 = D-side, 0 = I-side
stall_cycles  out  CNT_W  saturating count of cycles with pc_write=0

Behaviour:
- Reset (async, reset_n=0): state=RUN, fill_req=0, fill_is_data=0, redirect_pending=0, redirect_pc=0, stall_cycles=0. Combinational outputs take RUN values with all hazard inputs low: all enables=1, all flushes=0, redirect_valid=0.
- States: RUN, DFILL, IFILL.
- RUN priority, highest first:
  - dcache_miss: all enables=0, mem_wb_flush=1. Next state DFILL. fill_req=1 and fill_is_data=1 on the next cycle only.
  - branch_taken: if_id_flush=1, id_ex_flush=1, ex_mem_flush=1, redirect_valid=1, redirect_pc=branch_target (combinational pass-through). Load-use is ignored this cycle.
  - Load-use: id_ex_mem_read && id_ex_rt!=0 && (id_ex_rt==if_id_rs || (if_id_uses_rt && id_ex_rt==if_id_rt)). Drive pc_write=0, if_id_write=0, id_ex_flush=1. Later stages advance.
  - icache_miss: pc_write=0, if_id_write=0, if_id_flush=0. Next state IFILL. fill_req=1 and fill_is_data=0 next cycle. Back end keeps running.
  - A load-use and an icache_miss in the same cycle: apply the load-use response and enter IFILL.
- DFILL: all enables=0, mem_wb_flush=1, every other input ignored. On fill_done, return to RUN; the next cycle re-evaluates RUN normally. The held branch in EX/MEM resolves then.
- IFILL: pc_write=0, if_id_write=0, id_ex_flush=1 (bubbles into the back end).
  - branch_taken in IFILL: latch redirect_pc<=branch_target, set redirect_pending=1, assert if_id_flush and ex_mem_flush. The fill cannot be cancelled.
  - dcache_miss in IFILL: freeze the back end (id_ex_write=0, ex_mem_write=0, mem_wb_flush=1) until the I-fill completes, then go to DFILL with fill_req/fill_is_data=1.
  - fill_done: return to RUN. If redirect_pending, that RUN cycle drives redirect_valid=1 with the latched redirect_pc and if_id_flush=1, then clears redirect_pending.
- A fill_done pulse received in RUN is ignored.
- Only one fill is outstanding at a time. fill_req never asserts in two consecutive cycles.
- stall_cycles increments each cycle pc_write=0 and saturates at all-ones.
- reset_n asserted mid-fill: return to RUN immediately and drop any pending redirect.

Decomposition:
- Shared package pipe_pkg: state enum (RUN/DFILL/IFILL), REG_W and ADDR_W constants, a struct bundling the stage enable/flush vector.
- One natural sub-module, hazard_detect: the combinational load-use comparator.
- FSM, redirect latch and counter remain in pipeline_ctrl.

Test Plan:
- Load-use: id_ex_mem_read=1, id_ex_rt=8, if_id_rs=8 → one cycle with pc_write=0, if_id_write=0, id_ex_flush=1. Same case with id_ex_rt=0 → no stall.
- Branch: branch_taken=1, target=0x0040_0020 in RUN → same cycle redirect_valid=1, redirect_pc=0x0040_0020, if_id/id_ex/ex_mem flushes=1. Simultaneous load-use is suppressed.
- D-miss: dcache_miss pulse, fill_done 6 cycles later → fill_req=1/fill_is_data=1 for exactly one cycle, all enables=0 for 7 cycles, stall_cycles=7.
- I-miss with branch: icache_miss, then branch_taken target=0x100 two cycles later, fill_done at cycle 5 → first RUN cycle shows redirect_valid=1, redirect_pc=0x100, if_id_flush=1.
- I-fill then D-miss: dcache_miss during IFILL → back end freezes. After fill_done, a second fill_req with fill_is_data=1 issues. State passes IFILL→DFILL→RUN.
- Reset mid-DFILL: reset_n low → state RUN, redirect_pending=0, stall_cycles=0, all enables=1 asynchronously.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipe_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned ADDR_W = 32;

  // Controller sequencing states
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DFILL = 2'd1,
    IFILL = 2'd2
  } pipeState_t;

  // Stage register enable/flush vector driven into the datapath
  typedef struct packed {
    logic pcWrite;
    logic ifIdWrite;
    logic idExWrite;
    logic exMemWrite;
    logic ifIdFlush;
    logic idExFlush;
    logic exMemFlush;
    logic memWbFlush;
  } stageCtrl_t;

  // Free-flowing pipeline: everything advances, nothing is squashed
  function automatic stageCtrl_t flowCtrl();
    stageCtrl_t c;
    c            = '0;
    c.pcWrite    = 1'b1;
    c.ifIdWrite  = 1'b1;
    c.idExWrite  = 1'b1;
    c.exMemWrite = 1'b1;
    return c;
  endfunction

  // Whole pipeline held while a data fill is outstanding; WB gets bubbles
  function automatic stageCtrl_t freezeCtrl();
    stageCtrl_t c;
    c            = '0;
    c.memWbFlush = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use comparator between the ID/EX load and the IF/ID sources.
module hazard_detect #(
  parameter int unsigned REG_W = pipe_pkg::REG_W
) (
  input  logic [REG_W-1:0] ifIdRs,
  input  logic [REG_W-1:0] ifIdRt,
  input  logic             ifIdUsesRt,
  input  logic             idExMemRead,
  input  logic [REG_W-1:0] idExRt,
  output logic             loadUse_c
);

  // Register zero never carries a real dependency
  assign loadUse_c = idExMemRead && (idExRt != '0) &&
                     ((idExRt == ifIdRs) || (ifIdUsesRt && (idExRt == ifIdRt)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: stage enables/flushes,
// branch redirects, and I/D cache fill sequencing.
module pipeline_ctrl #(
  parameter int unsigned REG_W  = pipe_pkg::REG_W,
  parameter int unsigned ADDR_W = pipe_pkg::ADDR_W,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [REG_W-1:0]  if_id_rs,
  input  logic [REG_W-1:0]  if_id_rt,
  input  logic              if_id_uses_rt,
  input  logic              id_ex_mem_read,
  input  logic [REG_W-1:0]  id_ex_rt,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              icache_miss,
  input  logic              dcache_miss,
  input  logic              fill_done,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              id_ex_write,
  output logic              ex_mem_write,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              ex_mem_flush,
  output logic              mem_wb_flush,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              fill_req,
  output logic              fill_is_data,
  output logic [CNT_W-1:0]  stall_cycles
);

  import pipe_pkg::*;

  pipeState_t  stateQ;
  pipeState_t  stateNext;
  stageCtrl_t  ctrl;

  logic              loadUse;
  logic              fillAccept;
  logic              frozen;
  logic              redirectValid;
  logic              useBranchPc;
  logic              latchRedirect;
  logic              clearPending;
  logic              setDPending;
  logic              clearDPending;
  logic              startFill;
  logic              startDataFill;

  logic              fillReqQ;
  logic              fillIsDataQ;
  logic              redirectPendingQ;
  logic [ADDR_W-1:0] redirectPcQ;
  logic              dPendingQ;
  logic [CNT_W-1:0]  stallQ;

  hazard_detect #(
    .REG_W (REG_W)
  ) u_hazard_detect (
    .ifIdRs      (if_id_rs),
    .ifIdRt      (if_id_rt),
    .ifIdUsesRt  (if_id_uses_rt),
    .idExMemRead (id_ex_mem_read),
    .idExRt      (id_ex_rt),
    .loadUse_c   (loadUse)
  );

  // A completion cannot coincide with the request that starts the fill
  assign fillAccept = fill_done && !fillReqQ;

  // Next-state and stage control decode
  always_comb begin
    stateNext     = stateQ;
    ctrl          = flowCtrl();
    frozen        = 1'b0;
    redirectValid = 1'b0;
    useBranchPc   = 1'b0;
    latchRedirect = 1'b0;
    clearPending  = 1'b0;
    setDPending   = 1'b0;
    clearDPending = 1'b0;
    startFill     = 1'b0;
    startDataFill = 1'b0;

    case (stateQ)
      RUN: begin
        if (dcache_miss) begin
          ctrl          = freezeCtrl();
          stateNext     = DFILL;
          startFill     = 1'b1;
          startDataFill = 1'b1;
        end else if (redirectPendingQ) begin
          // Branch resolved during an I-fill: steer fetch now that the fill is back
          redirectValid  = 1'b1;
          ctrl.ifIdFlush = 1'b1;
          clearPending   = 1'b1;
        end else if (branch_taken) begin
          redirectValid   = 1'b1;
          useBranchPc     = 1'b1;
          ctrl.ifIdFlush  = 1'b1;
          ctrl.idExFlush  = 1'b1;
          ctrl.exMemFlush = 1'b1;
        end else begin
          if (loadUse) begin
            ctrl.pcWrite   = 1'b0;
            ctrl.ifIdWrite = 1'b0;
            ctrl.idExFlush = 1'b1;
          end
          if (icache_miss) begin
            ctrl.pcWrite   = 1'b0;
            ctrl.ifIdWrite = 1'b0;
            stateNext      = IFILL;
            startFill      = 1'b1;
          end
        end
      end

      IFILL: begin
        ctrl.pcWrite   = 1'b0;
        ctrl.ifIdWrite = 1'b0;
        frozen         = dcache_miss || dPendingQ;
        if (frozen) begin
          // Hold ID/EX and EX/MEM intact until the data fill can be issued
          ctrl.idExWrite  = 1'b0;
          ctrl.exMemWrite = 1'b0;
          ctrl.memWbFlush = 1'b1;
          setDPending     = dcache_miss;
        end else begin
          ctrl.idExFlush = 1'b1;
          if (branch_taken) begin
            latchRedirect   = 1'b1;
            ctrl.ifIdFlush  = 1'b1;
            ctrl.exMemFlush = 1'b1;
          end
        end
        if (fillAccept) begin
          if (frozen) begin
            stateNext     = DFILL;
            startFill     = 1'b1;
            startDataFill = 1'b1;
            clearDPending = 1'b1;
          end else begin
            stateNext = RUN;
          end
        end
      end

      DFILL: begin
        ctrl = freezeCtrl();
        if (fillAccept) begin
          stateNext = RUN;
        end
      end

      default: begin
        stateNext = RUN;
      end
    endcase
  end

  // State, fill request, redirect latch and stall counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stateQ           <= RUN;
      fillReqQ         <= 1'b0;
      fillIsDataQ      <= 1'b0;
      redirectPendingQ <= 1'b0;
      redirectPcQ      <= '0;
      dPendingQ        <= 1'b0;
      stallQ           <= '0;
    end else begin
      stateQ      <= stateNext;
      fillReqQ    <= startFill;
      fillIsDataQ <= startFill && startDataFill;
      if (latchRedirect) begin
        redirectPendingQ <= 1'b1;
        redirectPcQ      <= branch_target;
      end else if (clearPending) begin
        redirectPendingQ <= 1'b0;
      end
      if (clearDPending) begin
        dPendingQ <= 1'b0;
      end else if (setDPending) begin
        dPendingQ <= 1'b1;
      end
      if (!ctrl.pcWrite && (stallQ != {CNT_W{1'b1}})) begin
        stallQ <= stallQ + CNT_W'(1);
      end
    end
  end

  // Drive the stage control vector and redirect onto the ports
  assign pc_write       = ctrl.pcWrite;
  assign if_id_write    = ctrl.ifIdWrite;
  assign id_ex_write    = ctrl.idExWrite;
  assign ex_mem_write   = ctrl.exMemWrite;
  assign if_id_flush    = ctrl.ifIdFlush;
  assign id_ex_flush    = ctrl.idExFlush;
  assign ex_mem_flush   = ctrl.exMemFlush;
  assign mem_wb_flush   = ctrl.memWbFlush;
  assign redirect_valid = redirectValid;
  assign redirect_pc    = useBranchPc ? branch_target : redirectPcQ;
  assign fill_req       = fillReqQ;
  assign fill_is_data   = fillIsDataQ;
  assign stall_cycles   = stallQ;

endmodule
